// File: rtl/rle_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rle_block_sequencer: reads 8-pair run/level words from SRAM and expands    |
// | them into 64 zig-zag coefficients per block. Option macro: RLE_DC_PRED_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rle_block_sequencer #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [111:0]      mem_data,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [7:0]        coef_data,
  output logic [5:0]        coef_index,
  output logic              block_last,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  nblk_q, nblk_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [111:0]      word_q, word_d;
  logic [2:0]        pair_idx_q, pair_idx_d;
  logic [5:0]        pos_q, pos_d;
  logic [5:0]        zcnt_q, zcnt_d;
  logic              fill_q, fill_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
`ifdef RLE_DC_PRED_EN
  logic [7:0]        prev_dc_q, prev_dc_d;
`endif

  logic [5:0] run;
  logic [7:0] level;
  logic [7:0] raw;
  logic [7:0] coef_val;
  logic       is_eob;
  logic       is_ovf;
  logic       emit_level;
  logic       xfer;

  always_comb begin
    // The current pair always sits in the top 14 bits; consumed pairs are shifted out.
    run        = word_q[111:106];
    level      = word_q[105:98];
    is_eob     = (run == 6'h3F);
    is_ovf     = ({1'b0, pos_q} + {1'b0, run}) > 7'd63;
    xfer       = valid_q & coef_ready;
    emit_level = !fill_q && !is_eob && !((zcnt_q == 6'd0) && is_ovf) && (zcnt_q == run);
    raw        = emit_level ? level : 8'h00;
`ifdef RLE_DC_PRED_EN
    coef_val   = (pos_q == 6'd0) ? prev_dc_q + raw : raw;
    prev_dc_d  = prev_dc_q;
`else
    coef_val   = raw;
`endif

    state_d    = state_q;
    addr_d     = addr_q;
    nblk_d     = nblk_q;
    blk_cnt_d  = blk_cnt_q;
    word_d     = word_q;
    pair_idx_d = pair_idx_q;
    pos_d      = pos_q;
    zcnt_d     = zcnt_q;
    fill_d     = fill_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          nblk_d     = num_blocks;
          blk_cnt_d  = '0;
          err_d      = 1'b0;
          pos_d      = 6'd0;
          zcnt_d     = 6'd0;
          fill_d     = 1'b0;
          pair_idx_d = 3'd0;
`ifdef RLE_DC_PRED_EN
          prev_dc_d  = 8'h00;
`endif
          state_d    = (num_blocks == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d  = mem_data;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (xfer) begin
          pos_d = pos_q + 6'd1;
          if (!fill_q && is_eob) begin
            fill_d = 1'b1;
          end else if (!fill_q && (zcnt_q == 6'd0) && is_ovf) begin
            fill_d = 1'b1;
            err_d  = 1'b1;
          end else if (emit_level) begin
            zcnt_d     = 6'd0;
            word_d     = word_q << 14;
            pair_idx_d = pair_idx_q + 3'd1;
          end else if (!fill_q) begin
            zcnt_d = zcnt_q + 6'd1;
          end
`ifdef RLE_DC_PRED_EN
          if (pos_q == 6'd0) prev_dc_d = coef_val;
`endif
          // Closing a block drops any pairs left in the word; the next block is word-aligned.
          if (pos_q == 6'd63) begin
            pos_d      = 6'd0;
            zcnt_d     = 6'd0;
            fill_d     = 1'b0;
            pair_idx_d = 3'd0;
            blk_cnt_d  = blk_cnt_q + CNT_W'(1);
            state_d    = ((blk_cnt_q + CNT_W'(1)) == nblk_q) ? S_DONE : S_FETCH;
          end else if (emit_level && (pair_idx_q == 3'd7)) begin
            pair_idx_d = 3'd0;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_d = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_EMIT);
    done_d   = (state_d == S_DONE);
    valid_d  = (state_d == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      nblk_q     <= '0;
      blk_cnt_q  <= '0;
      word_q     <= '0;
      pair_idx_q <= 3'd0;
      pos_q      <= 6'd0;
      zcnt_q     <= 6'd0;
      fill_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef RLE_DC_PRED_EN
      prev_dc_q  <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nblk_q     <= nblk_d;
      blk_cnt_q  <= blk_cnt_d;
      word_q     <= word_d;
      pair_idx_q <= pair_idx_d;
      pos_q      <= pos_d;
      zcnt_q     <= zcnt_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
`ifdef RLE_DC_PRED_EN
      prev_dc_q  <= prev_dc_d;
`endif
    end
  end

  assign mem_rd       = mem_rd_q;
  assign mem_addr     = addr_q;
  assign coef_valid   = valid_q;
  assign coef_data    = valid_q ? coef_val : 8'h00;
  assign coef_index   = valid_q ? pos_q : 6'd0;
  assign block_last   = valid_q && (pos_q == 6'd63);
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;

endmodule
`default_nettype wire

// File: doc/rle_block_sequencer.md
# rle_block_sequencer

Sequencer that feeds the JPEG decoding datapath from the run/level coefficient SRAM (16384 × 112). It generates read addresses, unpacks the eight 14-bit (run, level) pairs in each word, and expands them into exactly 64 coefficients per 8×8 block in zig-zag order. Coefficients are delivered one per cycle through a valid/ready handshake. Upstream control sees a start/busy/done interface, so a frame of N blocks is decoded with a single command.

## Interface
- ADDR_W, 14, SRAM word-address width
- CNT_W, 10, block-count width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; ignored while busy=1
- base_addr  in  ADDR_W  first SRAM word of the frame, latched on start
- num_blocks  in  CNT_W  blocks to decode, latched on start
- mem_rd  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM read address
- mem_data  in  112  SRAM read data, valid the cycle after mem_rd
- coef_valid  out  1  coefficient available
- coef_ready  in  1  downstream accepts the coefficient
- coef_data  out  8  coefficient value (level or 0)
- coef_index  out  6  zig-zag position 0..63
- block_last  out  1  high with coef_index=63
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last block completes
- err_overflow  out  1  sticky flag; cleared on reset or on an accepted start

## Operation
- Pair k (k=0..7) occupies mem_data[111-14k -: 14]: run = upper 6 bits, level = lower 8 bits. Pair 0 is processed first.
- run=6'b111111 is EOB. Zeros are emitted up to and including index 63, and the block closes.
- Otherwise the block emits run zeros and then level at pos+run. pos advances by run+1.
- If pos+run>63, err_overflow is set. Zeros are emitted through index 63, and the block closes.
- When pos reaches 64 with no EOB, the block closes.
- After a block closes, the remaining pairs of the current word are discarded. The next block starts at the next SRAM word, so every block is word-aligned.
- If all 8 pairs are consumed with the block still open, the next word is fetched and expansion continues.
- The address increments by 1 per fetch and wraps from 2^ADDR_W−1 to 0.
- Block counter: the frame ends when the closed-block count equals num_blocks. num_blocks=0 produces a done pulse with no fetch.
- States:
  - IDLE: start → FETCH, or → DONE if num_blocks=0.
  - FETCH: mem_rd=1 → WAIT.
  - WAIT: mem_data captured into the word register → EMIT.
  - EMIT: one coefficient per handshake. On block close → DONE if it was the last block, else FETCH. On word exhausted → FETCH.
  - DONE: done=1 → IDLE.
- Reset values: all outputs 0, state IDLE, counters 0, err_overflow 0.
- Reset mid-operation aborts immediately with no done pulse.

## Timing
- start sampled at edge t. FETCH occupies cycle t+1, WAIT cycle t+2. First coef_valid is asserted in cycle t+3 if num_blocks>0.
- In EMIT, coef_valid stays high and coef_data/coef_index/block_last stay stable until coef_ready=1. A transfer occurs on a cycle with valid&ready.
- A coef_ready low for one cycle stalls expansion by exactly one cycle.
- Each word refetch inserts 2 bubble cycles (FETCH, WAIT) with coef_valid=0.
- done pulses the cycle after the final transfer (block_last=1). busy falls in the same cycle as the done pulse.
- start coinciding with done is ignored. A new start is accepted only in IDLE.

## Configuration
- RLE_DC_PRED_EN defined:
  - The index-0 coefficient is treated as a DC difference.
  - coef_data at index 0 = prev_dc + level, computed modulo 256.
  - prev_dc is updated per block and cleared on reset and on accepted start.
  - An EOB at pos 0 yields coef_data = prev_dc.
- RLE_DC_PRED_EN undefined: index 0 is passed through unmodified and no prev_dc register exists.

## Test plan
- Single block, word0 = pair0 (run 0, level 0x12), pair1 (run 2, level 0x05), pair2 EOB, rest arbitrary.
  - Coefficients: idx0=0x12, idx1–2=0, idx3=0x05, idx4–63=0.
  - block_last at idx63; done one cycle later; one mem_rd, at base_addr.
- Block spanning words: 8 pairs of (run 0, level k+1) followed by word1 = pair0 EOB.
  - idx0–7 = 1..8, then 2-cycle valid gap, then idx8–63 = 0.
  - mem_addr sequence base, base+1.
- Two blocks, num_blocks=2: block 0 closes on EOB at pair 3.
  - Block 1 begins from word base+1, pair 0; pairs 4–7 of word base are discarded.
  - done pulses after the second block_last.
- Overflow: pair0 (run 60, level 1), pair1 (run 5, level 2).
  - idx60=1, idx61–63=0, err_overflow=1 and held until the next start.
- Backpressure and reset: coef_ready toggled 1,0,1,0 gives stable data while ready=0.
  - Asserting reset mid-block gives all outputs 0 the next cycle, no done, and IDLE.
  - num_blocks=0 produces a done pulse at t+1 with no mem_rd.
- DC prediction (RLE_DC_PRED_EN defined): block DC diffs 0x10 then 0xF8.
  - Output idx0 = 0x10, then 0x08.
